// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - GET/PUT/DELETE command front end for the memory_cell array
module cache_controller #(
  parameter int NUM_CELLS   = 8,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64,
  parameter int IDX_W       = $clog2(NUM_CELLS),
  parameter int CNT_W       = $clog2(NUM_CELLS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [KEY_WIDTH-1:0]             cmd_key,
  input  logic [VALUE_WIDTH-1:0]           cmd_value,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [1:0]                       rsp_status,
  output logic [VALUE_WIDTH-1:0]           rsp_value,
  output logic [NUM_CELLS-1:0]             cell_write_op,
  output logic [KEY_WIDTH-1:0]             cell_key_in,
  output logic [VALUE_WIDTH-1:0]           cell_value_in,
  input  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_key_out,
  input  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_value_out,
  input  logic [NUM_CELLS-1:0]             cell_used_out,
  output logic [CNT_W-1:0]                 used_count
);

  localparam logic [1:0] OP_GET = 2'b01;
  localparam logic [1:0] OP_PUT = 2'b10;
  localparam logic [1:0] OP_DEL = 2'b11;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  localparam logic [NUM_CELLS-1:0] ONE_HOT_0 = NUM_CELLS'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                 state;
  logic [1:0]             op_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;

  logic                   hit_found;
  logic [IDX_W-1:0]       hit_idx;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [VALUE_WIDTH-1:0] hit_value;

  logic                   dec_write;
  logic [IDX_W-1:0]       dec_target;
  logic [KEY_WIDTH-1:0]   dec_key;
  logic [VALUE_WIDTH-1:0] dec_value;
  logic [1:0]             dec_status;
  logic [VALUE_WIDTH-1:0] dec_rsp_value;

  // Parallel search of all cells; descending scan leaves the lowest matching index
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (cell_used_out[i] && (cell_key_out[i*KEY_WIDTH +: KEY_WIDTH] == key_q)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!cell_used_out[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign hit_value = cell_value_out[hit_idx*VALUE_WIDTH +: VALUE_WIDTH];

  // Lookup decision: the priority chain that picks status, response value and write target
  always_comb begin
    dec_write     = 1'b0;
    dec_target    = '0;
    dec_key       = '0;
    dec_value     = '0;
    dec_status    = ST_ERR;
    dec_rsp_value = '0;
    if ((key_q == '0) || (op_q == 2'b00)) begin
      dec_status = ST_ERR;
    end else if (op_q == OP_GET) begin
      if (hit_found) begin
        dec_status    = ST_OK;
        dec_rsp_value = hit_value;
      end else begin
        dec_status = ST_MISS;
      end
    end else if (op_q == OP_PUT) begin
      if (hit_found || free_found) begin
        dec_write  = 1'b1;
        dec_target = hit_found ? hit_idx : free_idx;
        dec_key    = key_q;
        dec_value  = value_q;
        dec_status = ST_OK;
      end else begin
        dec_status = ST_FULL;
      end
    end else if (op_q == OP_DEL) begin
      if (hit_found) begin
        // A delete is a write of the empty key with a cleared value
        dec_write  = 1'b1;
        dec_target = hit_idx;
        dec_status = ST_OK;
      end else begin
        dec_status = ST_MISS;
      end
    end
  end

  // Occupancy is a plain popcount of the cells' used flags
  always_comb begin
    used_count = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      used_count = used_count + CNT_W'(cell_used_out[i]);
    end
  end

  // Command FSM with all handshake and cell-bus outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= 2'b00;
      key_q         <= '0;
      value_q       <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_status    <= ST_OK;
      rsp_value     <= '0;
      cell_write_op <= '0;
      cell_key_in   <= '0;
      cell_value_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            key_q     <= cmd_key;
            value_q   <= cmd_value;
            cmd_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          rsp_status <= dec_status;
          rsp_value  <= dec_rsp_value;
          if (dec_write) begin
            cell_write_op <= ONE_HOT_0 << dec_target;
            cell_key_in   <= dec_key;
            cell_value_in <= dec_value;
            state         <= WRITE;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          cell_write_op <= '0;
          cell_key_in   <= '0;
          cell_value_in <= '0;
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_status <= ST_OK;
            rsp_value  <= '0;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench for cache_controller
module tb_cache_controller;

  localparam int N  = 8;
  localparam int KW = 8;
  localparam int VW = 64;

  localparam logic [1:0] OP_GET = 2'b01;
  localparam logic [1:0] OP_PUT = 2'b10;
  localparam logic [1:0] OP_DEL = 2'b11;
  localparam logic [1:0] S_OK   = 2'b00;
  localparam logic [1:0] S_MISS = 2'b01;
  localparam logic [1:0] S_FULL = 2'b10;
  localparam logic [1:0] S_ERR  = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [KW-1:0] cmd_key;
  logic [VW-1:0] cmd_value;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_status;
  logic [VW-1:0] rsp_value;
  logic [N-1:0]  cell_write_op;
  logic [KW-1:0] cell_key_in;
  logic [VW-1:0] cell_value_in;
  logic [N*KW-1:0] cell_key_out;
  logic [N*VW-1:0] cell_value_out;
  logic [N-1:0]  cell_used_out;
  logic [3:0]    used_count;

  int errors = 0;
  int checks = 0;

  cache_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_value(rsp_value),
    .cell_write_op(cell_write_op), .cell_key_in(cell_key_in), .cell_value_in(cell_value_in),
    .cell_key_out(cell_key_out), .cell_value_out(cell_value_out),
    .cell_used_out(cell_used_out), .used_count(used_count)
  );

  always #5 clk = ~clk;

  // Behavioural memory cells: capture the shared buses on their strobe; empty key means unused
  logic          cells_clr;
  logic [KW-1:0] ck [N];
  logic [VW-1:0] cv [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (cells_clr) begin
        ck[i] <= '0;
        cv[i] <= '0;
      end else if (cell_write_op[i]) begin
        ck[i] <= cell_key_in;
        cv[i] <= cell_value_in;
      end
    end
  end

  always_comb begin
    cell_key_out   = '0;
    cell_value_out = '0;
    cell_used_out  = '0;
    for (int i = 0; i < N; i++) begin
      cell_key_out[i*KW +: KW]   = ck[i];
      cell_value_out[i*VW +: VW] = cv[i];
      cell_used_out[i]           = (ck[i] != '0);
    end
  end

  // Reference store contents and expected results for the last modelled command
  logic [KW-1:0] m_key [N];
  logic [VW-1:0] m_val [N];
  logic [1:0]    exp_status;
  logic [VW-1:0] exp_value;
  logic [N-1:0]  exp_mask;
  logic [7:0]    exp_lat;

  logic [1:0]    obs_status;
  logic [VW-1:0] obs_value;
  logic [N-1:0]  obs_mask;
  logic [3:0]    obs_wrcyc;
  logic [7:0]    obs_lat;
  logic          obs_rdy;

  task automatic model_cmd(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val);
    int hit;
    int fr;
    int tgt;
    hit = -1;
    fr  = -1;
    for (int i = 0; i < N; i++) begin
      if (m_key[i] != 0 && m_key[i] == key && hit < 0) hit = i;
      if (m_key[i] == 0 && fr < 0) fr = i;
    end
    exp_mask  = '0;
    exp_value = '0;
    exp_lat   = 8'd2;
    if (key == 0 || op == 2'b00) begin
      exp_status = S_ERR;
    end else if (op == OP_GET) begin
      exp_status = (hit >= 0) ? S_OK : S_MISS;
      if (hit >= 0) exp_value = m_val[hit];
    end else if (op == OP_PUT) begin
      tgt = (hit >= 0) ? hit : fr;
      if (tgt < 0) begin
        exp_status = S_FULL;
      end else begin
        exp_status = S_OK;
        exp_mask   = N'(1) << tgt;
        exp_lat    = 8'd3;
        m_key[tgt] = key;
        m_val[tgt] = val;
      end
    end else begin
      if (hit >= 0) begin
        exp_status = S_OK;
        exp_mask   = N'(1) << hit;
        exp_lat    = 8'd3;
        m_key[hit] = '0;
        m_val[hit] = '0;
      end else begin
        exp_status = S_MISS;
      end
    end
  endtask

  function automatic logic [86:0] got_t();
    return {obs_status, obs_value, obs_mask, obs_wrcyc, obs_lat, obs_rdy};
  endfunction

  function automatic logic [86:0] exp_t();
    return {exp_status, exp_value, exp_mask, (exp_mask != 0) ? 4'd1 : 4'd0, exp_lat, 1'b1};
  endfunction

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (m_key[i] != 0) c++;
    return c;
  endfunction

  function automatic bit state_ok();
    bit ok;
    ok = (int'(used_count) == model_count());
    for (int i = 0; i < N; i++) if (ck[i] !== m_key[i] || cv[i] !== m_val[i]) ok = 0;
    return ok;
  endfunction

  // Issue one command from a negedge, observe latency and strobes, then take the response
  task automatic do_cmd(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val, input int hold);
    int n;
    model_cmd(op, key, val);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    cmd_value = val;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_key   = 8'($urandom);
    cmd_value = {$urandom, $urandom};
    obs_lat   = '0;
    obs_mask  = '0;
    obs_wrcyc = '0;
    while (obs_lat < 8'd20) begin
      @(negedge clk);
      obs_lat++;
      if (cell_write_op != '0) begin
        obs_wrcyc++;
        obs_mask |= cell_write_op;
      end
      if (rsp_valid === 1'b1) break;
    end
    obs_status = rsp_status;
    obs_value  = rsp_value;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    obs_rdy   = cmd_ready;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cells_clr = 1'b1;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_key   = '0;
    cmd_value = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_key[i] = '0;
      m_val[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_status, rsp_value, cell_write_op, cell_key_in, cell_value_in} !== {1'b1, 1'b0, 2'b00, 64'd0, 8'd0, 8'd0, 64'd0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b st=%h val=%h wr=%h k=%h v=%h required rdy=1 all others 0",
               cmd_ready, rsp_valid, rsp_status, rsp_value, cell_write_op, cell_key_in, cell_value_in);
    end
    cells_clr = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    do_cmd(OP_GET, 8'h05, 64'd0, 0);
    checks++;
    if (got_t() !== exp_t()) begin
      errors++;
      $display("FAIL empty_get got=%h required=%h", got_t(), exp_t());
    end
    checks++;
    if (used_count !== 4'd0) begin
      errors++;
      $display("FAIL empty_used_count got=%0d required=0", used_count);
    end
  endtask

  task automatic test_put_get();
    do_cmd(OP_PUT, 8'h05, 64'hDEADBEEF_00000001, 0);
    checks++;
    if (got_t() !== exp_t() || obs_mask !== 8'h01) begin
      errors++;
      $display("FAIL put_rsp got=%h required=%h", got_t(), exp_t());
    end
    do_cmd(OP_GET, 8'h05, 64'd0, 1);
    checks++;
    if (got_t() !== exp_t() || obs_value !== 64'hDEADBEEF_00000001) begin
      errors++;
      $display("FAIL get_after_put got=%h required=%h", got_t(), exp_t());
    end
    checks++;
    if (!state_ok() || used_count !== 4'd1) begin
      errors++;
      $display("FAIL put_get_state used_count got=%0d required=1", used_count);
    end
  endtask

  task automatic test_overwrite_delete();
    logic [1:0]    ops [5];
    logic [VW-1:0] vals [5];
    ops  = '{OP_PUT, OP_PUT, OP_GET, OP_DEL, OP_GET};
    vals = '{64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, 64'd0, 64'd0};
    for (int i = 0; i < 5; i++) begin
      do_cmd(ops[i], 8'h05, vals[i], i % 2);
      checks++;
      if (got_t() !== exp_t()) begin
        errors++;
        $display("FAIL overwrite_step%0d got=%h required=%h", i, got_t(), exp_t());
      end
      checks++;
      if (!state_ok()) begin
        errors++;
        $display("FAIL overwrite_state%0d used_count got=%0d required=%0d cell0 got=%h/%h required=%h/%h",
                 i, used_count, model_count(), ck[0], cv[0], m_key[0], m_val[0]);
      end
    end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 8; k++) begin
      do_cmd(OP_PUT, 8'(k), {32'hF00D0000, 32'(k)}, 0);
      checks++;
      if (got_t() !== exp_t() || obs_mask !== (8'h01 << (k - 1))) begin
        errors++;
        $display("FAIL fill_key%0d got=%h required=%h", k, got_t(), exp_t());
      end
    end
    do_cmd(OP_PUT, 8'h09, 64'h9999, 0);
    checks++;
    if (got_t() !== exp_t() || obs_status !== S_FULL) begin
      errors++;
      $display("FAIL put_when_full got=%h required=%h", got_t(), exp_t());
    end
    do_cmd(OP_DEL, 8'h03, 64'd0, 0);
    checks++;
    if (got_t() !== exp_t()) begin
      errors++;
      $display("FAIL delete3 got=%h required=%h", got_t(), exp_t());
    end
    do_cmd(OP_PUT, 8'h09, 64'h9999, 0);
    checks++;
    if (got_t() !== exp_t() || obs_mask !== 8'h04) begin
      errors++;
      $display("FAIL retry_put9 got=%h required=%h", got_t(), exp_t());
    end
    checks++;
    if (!state_ok() || used_count !== 4'd8) begin
      errors++;
      $display("FAIL full_state used_count got=%0d required=8", used_count);
    end
  endtask

  task automatic test_illegal();
    do_cmd(OP_PUT, 8'h00, 64'h1234, 0);
    checks++;
    if (got_t() !== exp_t() || obs_status !== S_ERR) begin
      errors++;
      $display("FAIL put_key0 got=%h required=%h", got_t(), exp_t());
    end
    do_cmd(2'b00, 8'h11, 64'h5678, 0);
    checks++;
    if (got_t() !== exp_t() || obs_status !== S_ERR) begin
      errors++;
      $display("FAIL op00 got=%h required=%h", got_t(), exp_t());
    end
  endtask

  task automatic test_backpressure_reset();
    logic [VW-1:0] old_val;
    model_cmd(OP_GET, 8'h09, 64'd0);
    old_val   = exp_value;
    cmd_valid = 1'b1;
    cmd_op    = OP_GET;
    cmd_key   = 8'h09;
    @(posedge clk);
    #1;
    cmd_op  = OP_DEL;
    cmd_key = 8'h01;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({rsp_valid, rsp_status, rsp_value, cmd_ready} !== {1'b1, S_OK, old_val, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%b st=%h val=%h rdy=%b required vld=1 st=0 val=%h rdy=0",
                 c, rsp_valid, rsp_status, rsp_value, cmd_ready, old_val);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_PUT;
    cmd_key   = 8'h09;
    cmd_value = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (cell_write_op !== 8'h04) begin
      errors++;
      $display("FAIL write_before_reset got=%h required=04", cell_write_op);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cell_write_op, rsp_valid, cmd_ready} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got wr=%h vld=%b rdy=%b required wr=00 vld=0 rdy=1", cell_write_op, rsp_valid, cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10 || !state_ok()) begin
      errors++;
      $display("FAIL after_reset got rdy=%b vld=%b cell2=%h required rdy=1 vld=0 cell2=%h", cmd_ready, rsp_valid, cv[2], m_val[2]);
    end
    do_cmd(OP_GET, 8'h09, 64'd0, 0);
    checks++;
    if (got_t() !== exp_t()) begin
      errors++;
      $display("FAIL get_after_dropped_put got=%h required=%h", got_t(), exp_t());
    end
  endtask

  task automatic test_random();
    logic [1:0]    op;
    logic [KW-1:0] key;
    for (int n = 0; n < 80; n++) begin
      op  = ($urandom_range(0, 19) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      key = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom_range(1, 12));
      repeat ($urandom_range(0, 1)) @(negedge clk);
      do_cmd(op, key, {$urandom, $urandom}, $urandom_range(0, 2));
      checks++;
      if (got_t() !== exp_t()) begin
        errors++;
        $display("FAIL random%0d op=%0d key=%h got=%h required=%h", n, op, key, got_t(), exp_t());
      end
      checks++;
      if (!state_ok()) begin
        errors++;
        $display("FAIL random_state%0d used_count got=%0d required=%0d", n, used_count, model_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_overwrite_delete();
    test_full();
    test_illegal();
    test_backpressure_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
